// File: rtl/logcap_capture_engine.sv
// Logic-capture core: synchronised probe sampling into a circular RAM, masked pattern
// trigger, programmable post-trigger depth and command-driven one-sample readout.
module logcap_capture_engine #(
  parameter int          ADDR_W  = 10,
  parameter int          DEPTH   = 1024,
  parameter logic [7:0]  VERSION = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] probe,
  input  logic       command_strobe,
  input  logic [7:0] command,
  input  logic [7:0] reg_out0,
  input  logic [7:0] reg_out1,
  input  logic [7:0] reg_out2,
  input  logic [7:0] reg_out3,
  input  logic [7:0] reg_out4,
  input  logic [7:0] reg_out5,
  input  logic [7:0] reg_out6,
  input  logic [7:0] reg_out7,
  output logic [7:0] reg_in0,
  output logic [7:0] reg_in1,
  output logic [7:0] reg_in2,
  output logic [7:0] reg_in3,
  output logic [7:0] reg_in4,
  output logic [7:0] reg_in5,
  output logic [7:0] reg_in6,
  output logic [7:0] reg_in7,
  output logic [7:0] status
);

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_W   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_A  = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r, state_nx_s;
  logic [7:0]        probe_meta_r, probe_sync_r;
  logic [7:0]        div_cnt_r;
  logic              cmd_arm_s, cmd_abort_s, cmd_read_s, cmd_rewind_s;
  logic              running_s, tick_s, wr_en_s, hit_s, enter_done_s;
  logic              rd_accept_s, rewind_ok_s;
  logic [15:0]       post_raw_s;
  logic [ADDR_W:0]   post_clamp_s;
  logic [ADDR_W:0]   post_cnt_r, remain_r, fill_r, fill_nx_s;
  logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_nx_s, trig_addr_r, rd_base_r;
  logic [ADDR_W-1:0] base_nx_s, trig_src_s, trig_idx_s, rd_addr_s, rd_idx_r;
  logic              wrapped_r, wrapped_nx_s, rd_empty_r;
  logic [ADDR_W:0]   rd_ptr_r, rd_ptr_inc_s;
  logic [1:0]        rd_stage_r;
  logic [7:0]        mem [DEPTH];
  logic [7:0]        mem_q_r;
  logic [7:0]        reg_in0_r, reg_in1_r, reg_in2_r, reg_in3_r, reg_in4_r;
  logic [7:0]        reg_in5_r, reg_in6_r, status_r;
  logic              unused_regs_s;

  assign unused_regs_s = ^{reg_out5, reg_out6, reg_out7};

  // Command decode and datapath helper terms
  always_comb begin
    cmd_arm_s    = command_strobe && (command == 8'h01);
    cmd_abort_s  = command_strobe && (command == 8'h02);
    cmd_read_s   = command_strobe && (command == 8'h03);
    cmd_rewind_s = command_strobe && (command == 8'h04);
    running_s    = (state_r == ST_ARMED) || (state_r == ST_POST);
    tick_s       = running_s && (div_cnt_r == reg_out4);
    // A command in the tick cycle wins; ARM/ABORT discard the tick.
    wr_en_s      = tick_s && !cmd_arm_s && !cmd_abort_s;
    hit_s        = ((probe_sync_r ^ reg_out0) & reg_out1) == 8'h00;
    wr_ptr_nx_s  = wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    wrapped_nx_s = wrapped_r || (wr_ptr_r == LAST_A);
    rd_accept_s  = cmd_read_s && (state_r == ST_DONE) && (rd_stage_r == 2'b00);
    rewind_ok_s  = cmd_rewind_s && (state_r == ST_DONE);
    rd_addr_s    = rd_base_r + rd_ptr_r[ADDR_W-1:0];
    rd_ptr_inc_s = rd_ptr_r + ONE_W;
  end

  // Post-trigger count clamp to 1..DEPTH
  always_comb begin
    post_raw_s = {reg_out3, reg_out2};
    if (post_raw_s == 16'h0000) begin
      post_clamp_s = ONE_W;
    end else if (post_raw_s > 16'(DEPTH)) begin
      post_clamp_s = DEPTH_W;
    end else begin
      post_clamp_s = post_raw_s[ADDR_W:0];
    end
  end

  // Values presented at the moment the FSM enters DONE (include the final write)
  always_comb begin
    if (fill_r == DEPTH_W) begin
      fill_nx_s = fill_r;
    end else begin
      fill_nx_s = fill_r + ONE_W;
    end
    if (wrapped_nx_s) begin
      base_nx_s = wr_ptr_nx_s;
    end else begin
      base_nx_s = {ADDR_W{1'b0}};
    end
    if (state_r == ST_ARMED) begin
      trig_src_s = wr_ptr_r;
    end else begin
      trig_src_s = trig_addr_r;
    end
    trig_idx_s = trig_src_s - base_nx_s;
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    if (cmd_arm_s) begin
      state_nx_s = ST_ARMED;
    end else if (cmd_abort_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_ARMED: begin
          if (wr_en_s && hit_s) begin
            state_nx_s = (post_cnt_r == ONE_W) ? ST_DONE : ST_POST;
          end else begin
            state_nx_s = ST_ARMED;
          end
        end
        ST_POST: begin
          if (wr_en_s && (remain_r == ONE_W)) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_POST;
          end
        end
        default: state_nx_s = state_r;
      endcase
    end
    enter_done_s = wr_en_s && (state_nx_s == ST_DONE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Two-flop probe synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      probe_meta_r <= 8'h00;
      probe_sync_r <= 8'h00;
    end else begin
      probe_meta_r <= probe;
      probe_sync_r <= probe_meta_r;
    end
  end

  // Sample divider
  always_ff @(posedge clk) begin
    if (reset || cmd_arm_s) begin
      div_cnt_r <= 8'h00;
    end else if (running_s && !tick_s) begin
      div_cnt_r <= div_cnt_r + 8'h01;
    end else begin
      div_cnt_r <= 8'h00;
    end
  end

  // Capture pointers, trigger bookkeeping and DONE-entry results
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= '0;
      fill_r      <= '0;
      wrapped_r   <= 1'b0;
      post_cnt_r  <= '0;
      remain_r    <= '0;
      trig_addr_r <= '0;
      rd_base_r   <= '0;
      reg_in3_r   <= 8'h00;
      reg_in4_r   <= 8'h00;
      reg_in5_r   <= 8'h00;
      reg_in6_r   <= 8'h00;
    end else if (cmd_arm_s) begin
      wr_ptr_r   <= '0;
      fill_r     <= '0;
      wrapped_r  <= 1'b0;
      post_cnt_r <= post_clamp_s;
    end else if (wr_en_s) begin
      wr_ptr_r  <= wr_ptr_nx_s;
      wrapped_r <= wrapped_nx_s;
      fill_r    <= fill_nx_s;
      if ((state_r == ST_ARMED) && hit_s) begin
        trig_addr_r <= wr_ptr_r;
        remain_r    <= post_cnt_r - ONE_W;
      end else if (state_r == ST_POST) begin
        remain_r <= remain_r - ONE_W;
      end
      if (enter_done_s) begin
        rd_base_r <= base_nx_s;
        reg_in3_r <= trig_idx_s[7:0];
        reg_in4_r <= 8'(trig_idx_s >> 8);
        reg_in5_r <= fill_nx_s[7:0];
        reg_in6_r <= 8'(fill_nx_s >> 8);
      end
    end
  end

  // Sample RAM write port
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_r] <= probe_sync_r;
    end
  end

  // Sample RAM registered read port
  always_ff @(posedge clk) begin
    if (rd_accept_s) begin
      mem_q_r <= mem[rd_addr_s];
    end
  end

  // Readout sequencing: stage 0 reads the RAM, stage 1 publishes and advances
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_stage_r <= 2'b00;
      rd_ptr_r   <= '0;
      rd_idx_r   <= '0;
      rd_empty_r <= 1'b0;
      reg_in0_r  <= 8'h00;
      reg_in1_r  <= 8'h00;
      reg_in2_r  <= 8'h00;
    end else if (cmd_arm_s) begin
      rd_stage_r <= 2'b00;
      rd_ptr_r   <= '0;
      rd_empty_r <= 1'b0;
    end else begin
      rd_stage_r <= {rd_stage_r[0], rd_accept_s};
      if (rd_accept_s) begin
        rd_idx_r <= rd_ptr_r[ADDR_W-1:0];
      end
      if (rewind_ok_s) begin
        rd_ptr_r   <= '0;
        rd_empty_r <= 1'b0;
      end else if (rd_stage_r[0]) begin
        reg_in0_r <= mem_q_r;
        reg_in1_r <= rd_idx_r[7:0];
        reg_in2_r <= 8'(rd_idx_r >> 8);
        if (rd_ptr_inc_s >= fill_r) begin
          rd_ptr_r   <= '0;
          rd_empty_r <= 1'b1;
        end else begin
          rd_ptr_r <= rd_ptr_inc_s;
        end
      end else if (enter_done_s) begin
        rd_ptr_r <= '0;
      end
    end
  end

  // Registered status byte
  always_ff @(posedge clk) begin
    if (reset) begin
      status_r <= 8'h01;
    end else begin
      status_r <= {1'b0, rd_empty_r, wrapped_r, |rd_stage_r,
                   state_r == ST_DONE, state_r == ST_POST,
                   state_r == ST_ARMED, state_r == ST_IDLE};
    end
  end

  assign reg_in0 = reg_in0_r;
  assign reg_in1 = reg_in1_r;
  assign reg_in2 = reg_in2_r;
  assign reg_in3 = reg_in3_r;
  assign reg_in4 = reg_in4_r;
  assign reg_in5 = reg_in5_r;
  assign reg_in6 = reg_in6_r;
  assign reg_in7 = VERSION;
  assign status  = status_r;

endmodule

// File: tb/tb_logcap_capture_engine.sv
// Directed bench for logcap_capture_engine: hand-computed capture, trigger, readout,
// divider spacing, abort and reset vectors.
module tb_logcap_capture_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] probe;
  logic       command_strobe;
  logic [7:0] command;
  logic [7:0] reg_out0, reg_out1, reg_out2, reg_out3, reg_out4;
  logic [7:0] reg_out5, reg_out6, reg_out7;
  logic [7:0] reg_in0, reg_in1, reg_in2, reg_in3, reg_in4, reg_in5, reg_in6, reg_in7;
  logic [7:0] status;

  int vectors = 0;
  int miscompares = 0;

  logcap_capture_engine dut (
    .clk(clk), .reset(reset), .probe(probe),
    .command_strobe(command_strobe), .command(command),
    .reg_out0(reg_out0), .reg_out1(reg_out1), .reg_out2(reg_out2), .reg_out3(reg_out3),
    .reg_out4(reg_out4), .reg_out5(reg_out5), .reg_out6(reg_out6), .reg_out7(reg_out7),
    .reg_in0(reg_in0), .reg_in1(reg_in1), .reg_in2(reg_in2), .reg_in3(reg_in3),
    .reg_in4(reg_in4), .reg_in5(reg_in5), .reg_in6(reg_in6), .reg_in7(reg_in7),
    .status(status)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmd(input logic [7:0] c);
    command = c;
    command_strobe = 1'b1;
    cyc(1);
    command_strobe = 1'b0;
    command = 8'h00;
  endtask

  task automatic rd();
    cmd(8'h03);
    cyc(3);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    int last_w;
    int nwr;
    reset = 1'b1; probe = 8'h00; command_strobe = 1'b0; command = 8'h00;
    reg_out0 = 8'h00; reg_out1 = 8'h00; reg_out2 = 8'h00; reg_out3 = 8'h00;
    reg_out4 = 8'h00; reg_out5 = 8'h00; reg_out6 = 8'h00; reg_out7 = 8'h00;
    cyc(3);
    reset = 1'b0;
    cyc(1);

    // 1: reset state
    check("rst_status", status, 8'h01);
    check("rst_in0", reg_in0, 8'h00);
    check("rst_in1", reg_in1, 8'h00);
    check("rst_in2", reg_in2, 8'h00);
    check("rst_in3", reg_in3, 8'h00);
    check("rst_in4", reg_in4, 8'h00);
    check("rst_in5", reg_in5, 8'h00);
    check("rst_in6", reg_in6, 8'h00);
    check("rst_in7", reg_in7, 8'h01);

    // 2: ramp probe, trigger on A5 with full mask, post=4, div=0
    reg_out0 = 8'hA5; reg_out1 = 8'hFF; reg_out2 = 8'h04; reg_out3 = 8'h00; reg_out4 = 8'h00;
    cyc(3);
    cmd(8'h01);
    for (int j = 1; j < 200; j++) begin
      probe = 8'(j);
      cyc(1);
    end
    check("t2_status_done", status, 8'h08);
    check("t2_trig_lo", reg_in3, 8'hA6);
    check("t2_trig_hi", reg_in4, 8'h00);
    check("t2_fill_lo", reg_in5, 8'hAA);
    check("t2_fill_hi", reg_in6, 8'h00);
    for (int k = 0; k < 170; k++) begin
      rd();
      if (k == 0) begin
        check("t2_rd0_data", reg_in0, 8'h00);
        check("t2_rd0_idx", reg_in1, 8'h00);
      end
      if (k >= 166) begin
        check("t2_rd_data", reg_in0, 16'(k - 1));
        check("t2_rd_idx_lo", reg_in1, 16'(k));
        check("t2_rd_idx_hi", reg_in2, 8'h00);
      end
    end
    check("t2_status_empty", status, 8'h48);

    // 3: mask 0, post 0 -> one sample; ARM from DONE shows armed status
    probe = 8'h3C; reg_out1 = 8'h00; reg_out2 = 8'h00; reg_out3 = 8'h00;
    cyc(3);
    cmd(8'h01);
    cyc(1);
    check("t3_status_armed", status, 8'h02);
    cyc(3);
    check("t3_status_done", status, 8'h08);
    check("t3_trig_lo", reg_in3, 8'h00);
    check("t3_fill_lo", reg_in5, 8'h01);
    rd();
    check("t3_rd1_data", reg_in0, 8'h3C);
    check("t3_rd1_idx", reg_in1, 8'h00);
    rd();
    check("t3_rd2_data", reg_in0, 8'h3C);
    check("t3_rd2_idx", reg_in1, 8'h00);
    check("t3_status_empty", status, 8'h48);

    // 4: long pre-trigger run wraps the buffer, post=10
    probe = 8'h00; reg_out0 = 8'hFF; reg_out1 = 8'hFF; reg_out2 = 8'd10; reg_out3 = 8'h00;
    cyc(3);
    cmd(8'h01);
    cyc(2000);
    probe = 8'hFF;
    cyc(30);
    check("t4_status", status, 8'h28);
    check("t4_trig_lo", reg_in3, 8'hF6);
    check("t4_trig_hi", reg_in4, 8'h03);
    check("t4_fill_lo", reg_in5, 8'h00);
    check("t4_fill_hi", reg_in6, 8'h04);
    for (int k = 0; k < 1024; k++) begin
      rd();
      if (k == 0) check("t4_oldest", reg_in0, 8'h00);
      if (k == 1013) check("t4_pre_trig", reg_in0, 8'h00);
      if (k == 1014) begin
        check("t4_trig_data", reg_in0, 8'hFF);
        check("t4_trig_idx_lo", reg_in1, 8'hF6);
        check("t4_trig_idx_hi", reg_in2, 8'h03);
      end
      if (k == 1023) check("t4_last_data", reg_in0, 8'hFF);
    end
    check("t4_status_empty", status, 8'h68);

    // 5: divider 3 -> writes 4 clocks apart; ABORT in POST; READ_NEXT ignored in IDLE
    probe = 8'h00; reg_out0 = 8'h77; reg_out1 = 8'hFF; reg_out2 = 8'h05; reg_out4 = 8'h03;
    cyc(3);
    cmd(8'h01);
    last_w = -1;
    nwr = 0;
    for (int i = 0; i < 20; i++) begin
      if (dut.wr_en_s === 1'b1) begin
        if (nwr == 0) check("t5_first_tick", 16'(i), 16'd3);
        else check("t5_tick_gap", 16'(i - last_w), 16'd4);
        last_w = i;
        nwr++;
      end
      cyc(1);
    end
    check("t5_tick_count", 16'(nwr), 16'd5);
    probe = 8'h77;
    cyc(10);
    check("t5_status_post", status, 8'h04);
    cmd(8'h02);
    cyc(1);
    check("t5_status_abort", status, 8'h01);
    rd();
    check("t5_ignored_data", reg_in0, 8'hFF);
    check("t5_ignored_idx_lo", reg_in1, 8'hFF);
    check("t5_ignored_idx_hi", reg_in2, 8'h03);
    check("t5_ignored_status", status, 8'h01);

    // 6: reset during POST
    reg_out1 = 8'h00; reg_out2 = 8'd100; reg_out4 = 8'h00;
    cmd(8'h01);
    cyc(5);
    check("t6_status_post", status, 8'h04);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("t6_status_rst", status, 8'h01);
    check("t6_in0", reg_in0, 8'h00);
    check("t6_in1", reg_in1, 8'h00);
    check("t6_in2", reg_in2, 8'h00);
    check("t6_in3", reg_in3, 8'h00);
    check("t6_in4", reg_in4, 8'h00);
    check("t6_in5", reg_in5, 8'h00);
    check("t6_in6", reg_in6, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
